// File: rtl/muldiv_sequencer_if.sv
//==============================================================================
// muldiv_sequencer_if : execute-stage <-> multiply/divide sequencer bus
// Revision 1.0
//==============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic [2:0]      funct3;
  logic            word_op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            ok;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, funct3, word_op, op1, op2, flush,
    input  ok, busy, done, result
  );

  modport slave (
    input  req_valid, funct3, word_op, op1, op2, flush,
    output ok, busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
//==============================================================================
// muldiv_sequencer : iterative RV64M shift-add multiply / restoring divide.
// Optional MULDIV_EARLY_OUT_EN: zero/overflow cases finish in one cycle.
// Revision 1.0
//==============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam int HW = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return XLEN'($signed(v << HW) >>> HW);
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
    return (v << HW) >> HW;
  endfunction

  // Operation state latched at accept
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic              is_div_q;
  logic              word_q;
  logic              sel_hi_q;
  logic              sel_rem_q;
  logic              neg_main_q;
  logic              neg_rem_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;

  // Accept-time decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic [XLEN-1:0] ext_a;
  logic [XLEN-1:0] ext_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;

  always_comb begin
    is_div   = bus.funct3[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_div) begin
      a_signed = ~bus.funct3[0];
      b_signed = ~bus.funct3[0];
    end else if (bus.word_op) begin
      a_signed = 1'b1;
      b_signed = 1'b1;
    end else begin
      a_signed = (bus.funct3[1:0] != 2'd3);
      b_signed = ~bus.funct3[1];
    end

    ext_a = bus.op1;
    ext_b = bus.op2;
    if (bus.word_op) begin
      ext_a = a_signed ? sext_word(bus.op1) : zext_word(bus.op1);
      ext_b = b_signed ? sext_word(bus.op2) : zext_word(bus.op2);
    end

    a_neg  = a_signed & ext_a[XLEN-1];
    b_neg  = b_signed & ext_b[XLEN-1];
    mag_a  = a_neg ? -ext_a : ext_a;
    mag_b  = b_neg ? -ext_b : ext_b;
    b_zero = (ext_b == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            div_ovf;
  logic            early;
  logic [XLEN-1:0] early_raw;
  logic [XLEN-1:0] early_res;

  always_comb begin
    div_ovf = is_div & ~bus.funct3[0] & (ext_b == '1) &
              (ext_a == (bus.word_op ? {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}}
                                     : {1'b1, {(XLEN-1){1'b0}}}));
    early     = is_div ? (b_zero | div_ovf) : ((ext_a == '0) | b_zero);
    early_raw = '0;
    if (is_div) begin
      if (b_zero) early_raw = bus.funct3[1] ? ext_a : '1;
      else        early_raw = bus.funct3[1] ? '0 : ext_a;
    end
    early_res = bus.word_op ? sext_word(early_raw) : early_raw;
  end
`endif

  // One iteration step: shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] div_sh;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + ({(XLEN+1){acc[0]}} & {1'b0, opnd});
    div_sh    = {acc[2*XLEN-2:0], 1'b0};
    // The bit shifted out of the remainder joins the trial subtraction
    div_trial = {acc[2*XLEN-1], div_sh[2*XLEN-1:XLEN]} - {1'b0, opnd};
    acc_step  = {mul_sum, acc[XLEN-1:1]};
    if (is_div_q) begin
      if (!div_trial[XLEN]) acc_step = {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
      else                  acc_step = div_sh;
    end
  end

  // Sign correction and half selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_pre;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    // Word multiplies run only HW steps, leaving the product HW bits high
    prod = word_q ? (acc >> HW) : acc;
    if (neg_main_q) prod = -prod;
    quo = acc[XLEN-1:0];
    rem = acc[2*XLEN-1:XLEN];
    if (neg_main_q) quo = -quo;
    if (neg_rem_q)  rem = -rem;
    if (is_div_q) res_pre = sel_rem_q ? rem : quo;
    else          res_pre = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    fix_res = word_q ? sext_word(res_pre) : res_pre;
  end

  logic ok_w;
  logic done_w;

  always_comb begin
    state_nxt = state;
    ok_w      = 1'b0;
    done_w    = 1'b0;
    unique case (state)
      IDLE: begin
        ok_w = ~bus.req_valid;
        if (bus.req_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt = early ? DONE : ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER:  if (cnt == '0) state_nxt = FIXUP;
      FIXUP: state_nxt = DONE;
      DONE: begin
        ok_w      = 1'b1;
        done_w    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      result_q   <= '0;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      is_div_q   <= 1'b0;
      word_q     <= 1'b0;
      sel_hi_q   <= 1'b0;
      sel_rem_q  <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_div_q   <= is_div;
            word_q     <= bus.word_op;
            sel_hi_q   <= ~is_div & ~bus.word_op & (bus.funct3[1:0] != 2'd0);
            sel_rem_q  <= bus.funct3[1];
            // Divide-by-zero keeps the all-ones quotient unsigned
            neg_main_q <= (a_neg ^ b_neg) & ~(is_div & b_zero);
            neg_rem_q  <= a_neg;
            cnt        <= bus.word_op ? CW'(HW - 1) : CW'(XLEN - 1);
            if (is_div) begin
              acc  <= {{XLEN{1'b0}}, (bus.word_op ? (mag_a << HW) : mag_a)};
              opnd <= mag_b;
            end else begin
              acc  <= {{XLEN{1'b0}}, mag_b};
              opnd <= mag_a;
            end
`ifdef MULDIV_EARLY_OUT_EN
            if (early) result_q <= early_res;
`endif
          end
        end
        ITER: begin
          if (!bus.flush) begin
            acc <= acc_step;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        FIXUP: if (!bus.flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.ok     = ok_w;
  assign bus.done   = done_w;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule

`default_nettype wire
